// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown of in-flight write latency, stalling on RAW/WAW.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and WAW-only stall counters.
module hazard_cnt #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] val,
    output logic [LAT_W-1:0] cnt
);
    // A new issue overrides the countdown of an older write to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 8,
    parameter int LAT_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic              branch_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic              regwrite_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [LAT_W-1:0]  lat_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o
`ifdef HAZARD_PERF_EN
    ,
    input  logic              perf_clr_i,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       waw_stalls_o
`endif
);
    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat_eff;
    logic [LAT_W-1:0] slack;
    logic             rs1_hz, rs2_hz, src_hz, waw_hz, live, accept;

    assign lat_eff = (lat_i > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat_i;

    // Normal consumers pick up a cnt==1 result through EX-EX forwarding; branches read in ID.
    assign slack  = branch_i ? LAT_W'(0) : LAT_W'(1);
    assign rs1_hz = rs1_used_i && (rs1_i != '0) && (cnt[rs1_i] > slack);
    assign rs2_hz = rs2_used_i && (rs2_i != '0) && (cnt[rs2_i] > slack);
    assign src_hz = rs1_hz || rs2_hz;
    assign waw_hz = regwrite_i && (rd_i != '0) && (cnt[rd_i] > lat_eff);

    assign live    = issue_valid_i && !flush_i;
    assign stall_o = live && (src_hz || waw_hz);
    assign accept  = live && !stall_o && regwrite_i && (rd_i != '0);
    assign busy_o  = |cnt;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        hazard_cnt #(.LAT_W(LAT_W)) u_cnt (
            .clk  (clk_i),
            .rst  (rst_i),
            .load (accept && (rd_i == REG_AW'(r))),
            .val  (lat_eff),
            .cnt  (cnt[r])
        );
    end

`ifdef HAZARD_PERF_EN
    logic waw_only;
    assign waw_only = stall_o && waw_hz && !src_hz;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            waw_stalls_o   <= '0;
        end else if (perf_clr_i) begin
            stall_cycles_o <= '0;
            waw_stalls_o   <= '0;
        end else begin
            if (stall_o && stall_cycles_o != '1)
                stall_cycles_o <= stall_cycles_o + 32'd1;
            if (waw_only && waw_stalls_o != '1)
                waw_stalls_o <= waw_stalls_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle model compare plus literal stall counts.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0, branch = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, regwrite = 1'b0, flush = 1'b0;
    logic [3:0] lat = '0;
    logic       stall, busy;
`ifdef HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] stall_cycles, waw_stalls;
`endif

    int tests = 0;
    int fails = 0;

    hazard_scoreboard dut (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .branch_i(branch),
        .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .regwrite_i(regwrite), .rd_i(rd), .lat_i(lat), .flush_i(flush),
        .stall_o(stall), .busy_o(busy)
`ifdef HAZARD_PERF_EN
        , .perf_clr_i(perf_clr), .stall_cycles_o(stall_cycles), .waw_stalls_o(waw_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Model: remaining cycles until each register's pending result is forwardable.
    int pend [32];

    function automatic int lat_clip(input int l);
        return (l > 8) ? 8 : l;
    endfunction

    function automatic bit src_wait(input bit used, input int r);
        int allowed;
        allowed = branch ? 0 : 1;
        return used && r != 0 && pend[r] > allowed;
    endfunction

    function automatic bit model_stall();
        bit hz;
        if (!issue_valid || flush) return 1'b0;
        hz = src_wait(rs1_used, int'(rs1)) || src_wait(rs2_used, int'(rs2));
        if (regwrite && rd != 0 && pend[rd] > lat_clip(int'(lat))) hz = 1'b1;
        return hz;
    endfunction

    function automatic bit model_busy();
        for (int r = 1; r < 32; r++) if (pend[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) pend[r] <= 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue_valid && !flush && !model_stall() && regwrite && int'(rd) == r)
                    pend[r] <= lat_clip(int'(lat));
                else if (pend[r] > 0)
                    pend[r] <= pend[r] - 1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            tests++;
            if (stall !== model_stall()) begin
                fails++;
                $display("FAIL cyc_stall t=%0t got=%b exp=%b", $time, stall, model_stall());
            end
            tests++;
            if (busy !== model_busy()) begin
                fails++;
                $display("FAIL cyc_busy t=%0t got=%b exp=%b", $time, busy, model_busy());
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Caller sits at a negedge; holds the instruction until accepted, returns stall count.
    task automatic issue(input bit br, input int s1, input bit u1, input int s2, input bit u2,
                         input bit rw, input int d, input int l, input bit fl, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        issue_valid = 1'b1; branch = br; flush = fl;
        rs1 = 5'(s1); rs1_used = u1; rs2 = 5'(s2); rs2_used = u2;
        regwrite = rw; rd = 5'(d); lat = 4'(l);
        for (int k = 0; k < 40 && !done; k++) begin
            #3;
            if (!stall) done = 1'b1;
            else stalls++;
            @(negedge clk);
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL issue_timeout rd=%0d stalls=%0d", d, stalls);
        end
        issue_valid = 1'b0; flush = 1'b0; branch = 1'b0;
        rs1_used = 1'b0; rs2_used = 1'b0; regwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int s;

    initial begin
        #1;
        check("reset_stall", int'(stall), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(2);
        #3 check("idle_busy", int'(busy), 0);
        @(negedge clk);

        // load x5 -> dependent add
        issue(0, 0, 0, 0, 0, 1, 5, 2, 0, s);  check("load_issue", s, 0);
        issue(0, 5, 1, 0, 0, 1, 6, 1, 0, s);  check("load_use", s, 1);
        idle(4);
        // ALU -> branch, load -> branch
        issue(0, 0, 0, 0, 0, 1, 7, 1, 0, s);
        issue(1, 0, 0, 7, 1, 0, 0, 0, 0, s);  check("alu_branch", s, 1);
        idle(3);
        issue(0, 0, 0, 0, 0, 1, 7, 2, 0, s);
        issue(1, 0, 0, 7, 1, 0, 0, 0, 0, s);  check("load_branch", s, 2);
        idle(3);
        // div x9 lat6: WAW with lat1 waits while cnt 6..2, then read of x9 is free
        issue(0, 0, 0, 0, 0, 1, 9, 6, 0, s);
        issue(0, 0, 0, 0, 0, 1, 9, 1, 0, s);  check("waw_div", s, 5);
        issue(0, 9, 1, 0, 0, 1, 10, 1, 0, s); check("read_after_waw", s, 0);
        idle(8);
        issue(0, 0, 0, 0, 0, 1, 9, 6, 0, s);
        issue(0, 9, 1, 9, 1, 1, 10, 1, 0, s); check("raw_div", s, 5);
        idle(8);
        // x0 never tracked, lat 0 never tracked
        issue(0, 0, 0, 0, 0, 1, 0, 5, 0, s);
        #3 check("x0_busy", int'(busy), 0);
        @(negedge clk);
        issue(0, 0, 0, 0, 0, 1, 12, 0, 0, s);
        #3 check("lat0_busy", int'(busy), 0);
        @(negedge clk);
        // flush with hazard: no stall, no accept, counter unchanged
        issue(0, 0, 0, 0, 0, 1, 5, 6, 0, s);
        issue(0, 5, 1, 0, 0, 1, 5, 1, 1, s);  check("flush_nostall", s, 0);
        issue(0, 5, 1, 0, 0, 1, 6, 1, 0, s);  check("after_flush", s, 4);
        idle(8);
        // lat 15 clipped to 8: branch waits while cnt 8..1
        issue(0, 0, 0, 0, 0, 1, 11, 15, 0, s);
        issue(1, 11, 1, 0, 0, 0, 0, 0, 0, s); check("lat_clip", s, 8);
        idle(3);
`ifdef HAZARD_PERF_EN
        perf_clr = 1'b1; @(negedge clk); perf_clr = 1'b0;
        issue(0, 0, 0, 0, 0, 1, 13, 4, 0, s);
        issue(0, 13, 1, 0, 0, 1, 14, 1, 0, s);
        #3 check("perf_stalls", int'(stall_cycles), 3);
        check("perf_waw", int'(waw_stalls), 0);
        perf_clr = 1'b1; @(negedge clk); perf_clr = 1'b0;
        #3 check("perf_clr", int'(stall_cycles), 0);
        @(negedge clk);
`endif
        // async reset while a stall is being asserted
        issue(0, 0, 0, 0, 0, 1, 3, 6, 0, s);
        issue_valid = 1'b1; rs1 = 5'd3; rs1_used = 1'b1;
        #1 check("pre_rst_stall", int'(stall), 1);
        rst = 1'b1;
        #1 check("rst_stall", int'(stall), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0; issue_valid = 1'b0; rs1_used = 1'b0;
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
